// File: rtl/cam_srl.sv
// cam_srl: SRL-bitmap content-addressable memory, 2^ADDR_WIDTH entries.
// Ports: clk/rst, write_addr/data/delete/enable, compare_data -> write_busy, match_*.
module cam_srl #(
  parameter int    DATA_WIDTH  = 64,
  parameter int    ADDR_WIDTH  = 5,
  parameter string CAM_STYLE   = "SRL",
  parameter int    SLICE_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    write_addr,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     write_delete,
  input  logic                     write_enable,
  input  logic [DATA_WIDTH-1:0]    compare_data,
  output logic                     write_busy,
  output logic [2**ADDR_WIDTH-1:0] match_many,
  output logic [2**ADDR_WIDTH-1:0] match_single,
  output logic [ADDR_WIDTH-1:0]    match_addr,
  output logic                     match
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int SD    = 2 ** SLICE_WIDTH;
  localparam int NS    = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
  localparam int PW    = NS * SLICE_WIDTH;

  if (CAM_STYLE != "SRL") begin : g_bad_style
    $error("cam_srl: unsupported CAM_STYLE");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [SLICE_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [PW-1:0]           data_q, data_d;
  logic                    del_q, del_d;
  logic [PW-1:0]           key_q, key_d;

  // srl_q[slice][entry][slice value]: one-hot per valid entry column
  logic [NS-1:0][DEPTH-1:0][SD-1:0] srl_q, srl_d;

  logic [DEPTH-1:0]      many_q, many_d;
  logic [DEPTH-1:0]      single_q, single_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic                  hit_q, hit_d;
  logic                  found;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    del_d   = del_q;
    srl_d   = srl_q;
    unique case (state_q)
      IDLE: begin
        if (write_enable || write_delete) begin
          state_d = SHIFT;
          cnt_d   = '1;
          addr_d  = write_addr;
          data_d  = PW'(write_data);
          del_d   = write_delete;
        end
      end
      SHIFT: begin
        // counting down: the bit shifted at count c lands at location c
        for (int s = 0; s < NS; s++) begin
          srl_d[s][addr_q] = {srl_q[s][addr_q][SD-2:0],
            ~del_q && (data_q[s*SLICE_WIDTH +: SLICE_WIDTH] == cnt_q)};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_d    = PW'(compare_data);
    many_d   = '1;
    single_d = '0;
    maddr_d  = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < NS; s++) begin
        if (!srl_q[s][i][key_q[s*SLICE_WIDTH +: SLICE_WIDTH]])
          many_d[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (many_d[i] && !found) begin
        single_d[i] = 1'b1;
        maddr_d     = ADDR_WIDTH'(i);
        found       = 1'b1;
      end
    end
    hit_d = |many_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      del_q    <= 1'b0;
      key_q    <= '0;
      srl_q    <= '0;
      many_q   <= '0;
      single_q <= '0;
      maddr_q  <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      del_q    <= del_d;
      key_q    <= key_d;
      srl_q    <= srl_d;
      many_q   <= many_d;
      single_q <= single_d;
      maddr_q  <= maddr_d;
      hit_q    <= hit_d;
    end
  end

  assign write_busy   = (state_q == SHIFT);
  assign match_many   = many_q;
  assign match_single = single_q;
  assign match_addr   = maddr_q;
  assign match        = hit_q;

endmodule

// File: tb/tb_cam_srl.sv
// tb_cam_srl: randomized scoreboard bench for cam_srl.
// Keys are queued with expected bitmaps; a monitor checks them two edges later.
module tb_cam_srl;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          write_delete;
  logic          write_enable;
  logic [DW-1:0] compare_data;
  logic          write_busy;
  logic [N-1:0]  match_many;
  logic [N-1:0]  match_single;
  logic [AW-1:0] match_addr;
  logic          match;

  cam_srl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAM_STYLE("SRL"),
            .SLICE_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .write_addr(write_addr), .write_data(write_data),
    .write_delete(write_delete), .write_enable(write_enable),
    .compare_data(compare_data), .write_busy(write_busy),
    .match_many(match_many), .match_single(match_single),
    .match_addr(match_addr), .match(match)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // reference contents: plain array of valid flags and words
  logic          mv[N];
  logic [DW-1:0] md[N];

  typedef struct {
    int            due;
    logic [DW-1:0] key;
    logic [N-1:0]  many;
  } exp_t;
  exp_t q[$];

  logic [DW-1:0] pool[4];

  function automatic logic [DW-1:0] tag(input int c, input int p);
    return {32'(c), 32'(p)};
  endfunction

  function automatic logic [N-1:0] model_many(input logic [DW-1:0] k);
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = mv[i] && (md[i] == k);
    return m;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic issue(input logic [DW-1:0] k);
    exp_t e;
    @(negedge clk);
    compare_data = k;
    e.due  = cyc + 2;
    e.key  = k;
    e.many = model_many(k);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] es;
    logic [AW-1:0] ea;
    if (q.size() > 0 && q[0].due == cyc) begin
      e  = q.pop_front();
      es = e.many & (~e.many + 1'b1);
      ea = AW'($clog2(es));
      total++;
      if (match_many === e.many && match_single === es &&
          match_addr === ea && match === (|e.many)) begin
        passed++;
      end else begin
        $display("FAIL cmp key=%0h: many=%0h single=%0h addr=%0d m=%0b expected many=%0h single=%0h addr=%0d m=%0b",
                 e.key, match_many, match_single, match_addr, match,
                 e.many, es, ea, |e.many);
      end
    end
  end

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic op(input int a, input logic [DW-1:0] d, input bit we,
                    input bit wd, input bit drop);
    int n;
    drain();
    @(negedge clk);
    write_addr   = AW'(a);
    write_data   = d;
    write_enable = we;
    write_delete = wd;
    if (wd) mv[a] = 1'b0;
    else if (we) begin
      mv[a] = 1'b1;
      md[a] = d;
    end
    @(negedge clk);
    write_enable = 1'b0;
    write_delete = 1'b0;
    n = 0;
    while (write_busy && n < 40) begin
      n++;
      if (drop && n == 5) begin
        write_addr   = AW'((a + 4) % N);
        write_data   = tag(9, 9);
        write_enable = 1'b1;
      end else begin
        write_enable = 1'b0;
      end
      @(negedge clk);
    end
    write_enable = 1'b0;
    chk("busy_len", 64'(n), 64'd16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int a, k;
    rst = 1'b1;
    write_addr = '0;
    write_data = '0;
    write_enable = 1'b0;
    write_delete = 1'b0;
    compare_data = '0;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    for (int i = 0; i < 4; i++) pool[i] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 64'(write_busy), 64'd0);
    repeat (20) issue('0);

    op(2, tag(1, 2), 1, 0, 0);
    issue(tag(1, 2));
    issue(tag(1, 3));
    issue(tag(11, 2));
    issue(64'd432);

    op(5, tag(1, 2), 1, 0, 0);
    op(2, tag(1, 2), 1, 0, 0);
    issue(tag(1, 2));
    op(2, '0, 0, 1, 0);
    issue(tag(1, 2));

    op(7, tag(4, 4), 1, 0, 1);
    issue(tag(9, 9));
    issue(tag(4, 4));
    issue(tag(1, 2));

    op(5, tag(6, 6), 1, 1, 0);
    issue(tag(1, 2));
    issue(tag(6, 6));
    issue(tag(4, 4));

    drain();
    @(negedge clk);
    write_addr   = 5'd3;
    write_data   = tag(3, 3);
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(write_busy), 64'd0);
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    issue(tag(4, 4));
    issue(tag(3, 3));
    issue('0);
    op(3, tag(3, 3), 1, 0, 0);
    issue(tag(3, 3));

    for (int t = 0; t < 60; t++) begin
      a = $urandom_range(0, 7);
      k = $urandom_range(0, 9);
      if (k < 6) op(a, pool[$urandom_range(0, 3)], 1, 0, 0);
      else if (k < 8) op(a, '0, 0, 1, 0);
      else op(a, pool[$urandom_range(0, 3)], 1, 1, 0);
      for (int j = 0; j < 3; j++) begin
        k = $urandom_range(0, 5);
        if (k < 4) issue(pool[k]);
        else if (k == 4) issue(pool[0] ^ (64'd1 << $urandom_range(0, 63)));
        else issue({$urandom, $urandom});
      end
    end

    drain();
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
